fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
// Instruction fetch stage placed directly upstream of the synchronous instruction
// memory (registered 32-bit read, address sampled on posedge clock, data valid next
// cycle). Owns the program counter, drives the byte address, tracks the one
// in-flight read and buffers returned words in a 2-entry queue. Presents
// {instruction, pc} to decode over a valid/ready handshake and accepts branch redirects.
//
// PARAMETERS
// NADDR_BITS  8   byte-address width; memory holds 2**(NADDR_BITS-2) words
// RESET_PC    0   pc after reset; bits [1:0] must be 0
//
// PORTS
// clock         in   1           rising-edge clock
// reset_n       in   1           asynchronous reset, active low
// mem_address   out  NADDR_BITS  byte address to instruction memory, driven straight from pc
// mem_q         in   32          memory read data; word for the address issued one cycle earlier
// halt          in   1           1 = issue no new reads; the in-flight read still completes
// redirect      in   1           1 = flush and restart fetch at redirect_pc
// redirect_pc   in   NADDR_BITS  new fetch byte address; bits [1:0] ignored, forced to 0
// ins_valid     out  1           queue head holds a valid instruction
// ins           out  32          instruction at queue head
// ins_pc        out  NADDR_BITS  byte address of ins
// ins_ready     in   1           decode accepts the head when ins_valid=1
//
// BEHAVIOUR
// - Reset (async, any time, including mid-fetch): pc=RESET_PC, so mem_address=RESET_PC.
//   Queue is emptied, both entries zeroed, so ins_valid=0, ins=0, ins_pc=0.
//   inflight_valid=0.
// - pop  = ins_valid & ins_ready.
//   issue = ~redirect & ~halt & (count + inflight_valid - pop < 2).
// - On issue at an edge: inflight_valid<=1, inflight_pc<=pc, pc<=pc+4.
//   pc wraps modulo 2**NADDR_BITS (last word -> 0).
// - Without issue, pc holds. mem_address stays at pc; the extra memory read is
//   harmless and is never captured.
// - Cycle after issue: if inflight_valid=1 and no redirect, {mem_q, inflight_pc} is
//   pushed to the queue tail at the edge. inflight_valid clears unless a new issue
//   occurs in the same cycle.
// - Push and pop may occur in the same cycle; count is unchanged. Overflow is
//   impossible by the issue rule; verify this with an assertion.
// - Latency: address issued in cycle t, instruction on ins in cycle t+2.
//   Throughput is 1 instruction/cycle while ins_ready stays high.
// - Back-pressure: with ins_ready=0 the queue fills to 2 and issue stops. pc then
//   equals the address of the next unfetched word. No instruction is lost or duplicated.
// - Redirect (priority over all else, in the same cycle):
//   - A pop in that cycle still completes; decode has taken that word.
//   - Queue is flushed (count=0) and inflight_valid<=0; the returning mem_q is discarded.
//   - pc <= {redirect_pc[NADDR_BITS-1:2], 2'b00}; there is no issue that cycle.
//   - Redirect in cycle r gives first issue in r+1 and target on ins in r+3.
// - Back-to-back redirects: the last one wins. Each flushes anything fetched for the previous one.
// - halt: blocks issue only; queued and in-flight words still drain to decode.
// - Outputs ins/ins_pc are don't-care while ins_valid=0 (except after reset: 0).
//
// TESTING
// - Reset then free run, memory[i]=i+1, ins_ready=1:
//   ins_valid rises on cycle 2; ins=1,2,3,... on consecutive cycles with
//   ins_pc=0x00,0x04,0x08,...
// - Stall: ins_ready=0 for 5 cycles mid-stream:
//   queue holds 2, mem_address frozen; on release the sequence continues with no gap
//   and no repeat.
// - Redirect to 0x43 with words in queue and in flight: stale words never appear;
//   ins_pc=0x40 exactly 3 cycles later. Repeat with pop in the redirect cycle;
//   that word is counted accepted.
// - Wrap: redirect to 0xF8 (NADDR_BITS=8): ins_pc sequence 0xF8,0xFC,0x00,0x04.
// - Halt for 4 cycles, then release: in-flight word delivered, then no new ins_valid
//   until release; order preserved.
// - Assert reset_n low mid-stream, asynchronous to clock:
//   ins_valid=0 and mem_address=RESET_PC immediately; fetch restarts from RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, redirect/halt controls and the decode handshake.
// master = fetch unit side, slave = memory/decode/environment side.
interface fetch_unit_if #(
    parameter int unsigned NADDR_BITS = 8
);
    logic [NADDR_BITS-1:0] mem_address;
    logic [31:0]           mem_q;
    logic                  halt;
    logic                  redirect;
    logic [NADDR_BITS-1:0] redirect_pc;
    logic                  ins_valid;
    logic [31:0]           ins;
    logic [NADDR_BITS-1:0] ins_pc;
    logic                  ins_ready;

    modport master (
        output mem_address, ins_valid, ins, ins_pc,
        input  mem_q, halt, redirect, redirect_pc, ins_ready
    );

    modport slave (
        input  mem_address, ins_valid, ins, ins_pc,
        output mem_q, halt, redirect, redirect_pc, ins_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the pc, tracks one in-flight synchronous memory read
// and buffers returned words in a 2-entry queue presented to decode.
module fetch_unit #(
    parameter int unsigned          NADDR_BITS = 8,
    parameter logic [NADDR_BITS-1:0] RESET_PC  = '0
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_unit_if.master bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned QDEPTH = 2;
    localparam int unsigned CNT_W  = 2;

    typedef struct packed {
        logic [DATA_W-1:0]     ins;
        logic [NADDR_BITS-1:0] pc;
    } entry_t;

    logic [NADDR_BITS-1:0] pc_q, pc_d;
    logic                  inflight_valid_q, inflight_valid_d;
    logic [NADDR_BITS-1:0] inflight_pc_q, inflight_pc_d;
    entry_t                entry_q [QDEPTH];
    entry_t                entry_d [QDEPTH];
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  valid_q, valid_d;

    logic                  pop_c;
    logic                  push_c;
    logic                  issue_c;
    logic [CNT_W-1:0]      kept_c;
    logic [CNT_W:0]        occupancy_c;

    // Occupancy counts queued words plus the read still in flight, so the queue can never overflow.
    assign pop_c       = valid_q & bus.ins_ready;
    assign push_c      = inflight_valid_q & ~bus.redirect;
    assign kept_c      = count_q - CNT_W'(pop_c);
    assign occupancy_c = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_valid_q) - (CNT_W+1)'(pop_c);
    assign issue_c     = ~bus.redirect & ~bus.halt & (occupancy_c < (CNT_W+1)'(QDEPTH));

    assign bus.mem_address = pc_q;
    assign bus.ins_valid   = valid_q;
    assign bus.ins         = entry_q[0].ins;
    assign bus.ins_pc      = entry_q[0].pc;

    always_comb begin
        pc_d             = pc_q;
        inflight_valid_d = issue_c;
        inflight_pc_d    = inflight_pc_q;
        entry_d          = entry_q;
        count_d          = count_q;

        if (bus.redirect) begin
            // Flush everything; the word returning this cycle belongs to the old stream.
            pc_d    = bus.redirect_pc & ~NADDR_BITS'(3);
            count_d = '0;
        end else begin
            if (issue_c) begin
                pc_d          = pc_q + NADDR_BITS'(4);
                inflight_pc_d = pc_q;
            end
            if (pop_c) begin
                entry_d[0] = entry_q[1];
            end
            count_d = kept_c;
            if (push_c) begin
                if (kept_c == '0) begin
                    entry_d[0] = {bus.mem_q, inflight_pc_q};
                end else begin
                    entry_d[1] = {bus.mem_q, inflight_pc_q};
                end
                count_d = kept_c + CNT_W'(1);
            end
        end

        valid_d = (count_d != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            count_q          <= '0;
            valid_q          <= 1'b0;
            for (int i = 0; i < int'(QDEPTH); i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            count_q          <= count_d;
            valid_q          <= valid_d;
            entry_q          <= entry_d;
        end
    end

    no_overflow_a : assert property (@(posedge clock) disable iff (!reset_n)
        !(push_c && !pop_c && (count_q == CNT_W'(QDEPTH))));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven free run/stall, hand-written redirect/wrap/halt/reset
// sequences, then random traffic against a stream-level reference model.
module tb_fetch_unit;
    localparam int unsigned NADDR_BITS = 8;
    localparam int unsigned NWORDS     = 64;
    localparam int unsigned NVEC       = 13;
    localparam int unsigned NRAND      = 3000;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    fetch_unit_if #(.NADDR_BITS(NADDR_BITS)) bus ();

    fetch_unit #(
        .NADDR_BITS(NADDR_BITS),
        .RESET_PC  (8'h00)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Synchronous instruction memory: address sampled at the edge, data valid next cycle.
    logic [31:0] mem [NWORDS];
    always @(posedge clock) bus.mem_q <= mem[bus.mem_address[NADDR_BITS-1:2]];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ready;
        logic        exp_valid;
        logic [31:0] exp_ins;
        logic [7:0]  exp_pc;
        logic [7:0]  exp_addr;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(logic r, logic h, logic rd, logic [7:0] rp);
        bus.ins_ready   = r;
        bus.halt        = h;
        bus.redirect    = rd;
        bus.redirect_pc = rp;
    endtask

    // With memory[i] = i+1 the word at byte address a is a/4 + 1.
    task automatic chk(string name, logic v, int pc, int addr);
        check({name, " valid"}, 64'(bus.ins_valid), 64'(v));
        if (v) begin
            check({name, " ins_pc"}, 64'(bus.ins_pc), 64'(pc));
            check({name, " ins"}, 64'(bus.ins), 64'(pc / 4 + 1));
        end
        if (addr >= 0) check({name, " mem_address"}, 64'(bus.mem_address), 64'(addr));
    endtask

    task automatic run_vec(int i);
        check($sformatf("vec%0d valid", i), 64'(bus.ins_valid), 64'(vecs[i].exp_valid));
        check($sformatf("vec%0d mem_address", i), 64'(bus.mem_address), 64'(vecs[i].exp_addr));
        if (vecs[i].exp_valid || i < 2) begin
            check($sformatf("vec%0d ins", i), 64'(bus.ins), 64'(vecs[i].exp_ins));
            check($sformatf("vec%0d ins_pc", i), 64'(bus.ins_pc), 64'(vecs[i].exp_pc));
        end
        drive(vecs[i].ready, 1'b0, 1'b0, 8'h00);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, h, rd, halt_st;
        logic [7:0]  rp, exp_pc;
        int          free_run;

        for (int i = 0; i < int'(NWORDS); i++) mem[i] = 32'(i + 1);

        // Free run from reset, then ready low for cycles 4..8.
        vecs[0]  = '{1'b1, 1'b0, 32'd0, 8'h00, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 32'd0, 8'h00, 8'h04};
        vecs[2]  = '{1'b1, 1'b1, 32'd1, 8'h00, 8'h08};
        vecs[3]  = '{1'b1, 1'b1, 32'd2, 8'h04, 8'h0C};
        vecs[4]  = '{1'b0, 1'b1, 32'd3, 8'h08, 8'h10};
        vecs[5]  = '{1'b0, 1'b1, 32'd3, 8'h08, 8'h10};
        vecs[6]  = '{1'b0, 1'b1, 32'd3, 8'h08, 8'h10};
        vecs[7]  = '{1'b0, 1'b1, 32'd3, 8'h08, 8'h10};
        vecs[8]  = '{1'b0, 1'b1, 32'd3, 8'h08, 8'h10};
        vecs[9]  = '{1'b1, 1'b1, 32'd3, 8'h08, 8'h10};
        vecs[10] = '{1'b1, 1'b1, 32'd4, 8'h0C, 8'h14};
        vecs[11] = '{1'b1, 1'b1, 32'd5, 8'h10, 8'h18};
        vecs[12] = '{1'b1, 1'b1, 32'd6, 8'h14, 8'h1C};

        drive(1'b1, 1'b0, 1'b0, 8'h00);
        step();
        step();
        reset_n = 1'b1;

        for (int i = 0; i < int'(NVEC); i++) run_vec(i);

        // Redirect to 0x43 with a queued word and one in flight, no pop.
        chk("redir pre", 1'b1, 'h18, 'h20); drive(1'b0, 1'b0, 1'b1, 8'h43); step();
        chk("redir r+1", 1'b0, 0, 'h40);    drive(1'b1, 1'b0, 1'b0, 8'h00); step();
        chk("redir r+2", 1'b0, 0, 'h44);    step();
        chk("redir r+3", 1'b1, 'h40, 'h48); step();
        // Redirect with a pop in the same cycle.
        chk("redirpop r", 1'b1, 'h44, 'h4C);  drive(1'b1, 1'b0, 1'b1, 8'h80); step();
        chk("redirpop r+1", 1'b0, 0, 'h80);   drive(1'b1, 1'b0, 1'b0, 8'h00); step();
        chk("redirpop r+2", 1'b0, 0, 'h84);   step();
        chk("redirpop r+3", 1'b1, 'h80, 'h88); step();
        // Wrap past the top of the address space.
        chk("wrap r", 1'b1, 'h84, 'h8C); drive(1'b1, 1'b0, 1'b1, 8'hF8); step();
        chk("wrap r+1", 1'b0, 0, 'hF8);  drive(1'b1, 1'b0, 1'b0, 8'h00); step();
        chk("wrap r+2", 1'b0, 0, 'hFC);  step();
        chk("wrap F8", 1'b1, 'hF8, 'h00); step();
        chk("wrap FC", 1'b1, 'hFC, 'h04); step();
        chk("wrap 00", 1'b1, 'h00, 'h08); step();
        chk("wrap 04", 1'b1, 'h04, 'h0C); step();
        // Halt for 4 cycles: queued and in-flight words drain, nothing new issued.
        chk("halt 0", 1'b1, 'h08, 'h10); drive(1'b1, 1'b1, 1'b0, 8'h00); step();
        chk("halt 1", 1'b1, 'h0C, 'h10); step();
        chk("halt 2", 1'b0, 0, 'h10);    step();
        chk("halt 3", 1'b0, 0, 'h10);    step();
        chk("release 0", 1'b0, 0, 'h10); drive(1'b1, 1'b0, 1'b0, 8'h00); step();
        chk("release 1", 1'b0, 0, 'h14); step();
        chk("release 2", 1'b1, 'h10, 'h18); step();

        // Asynchronous reset in mid-cycle.
        chk("prereset", 1'b1, 'h14, 'h1C);
        #3;
        reset_n = 1'b0;
        #1;
        check("async reset valid", 64'(bus.ins_valid), 64'(0));
        check("async reset mem_address", 64'(bus.mem_address), 64'(0));
        check("async reset ins", 64'(bus.ins), 64'(0));
        check("async reset ins_pc", 64'(bus.ins_pc), 64'(0));
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) run_vec(i);

        // Random traffic with random memory contents.
        for (int i = 0; i < int'(NWORDS); i++) mem[i] = $urandom;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        reset_n  = 1'b1;
        exp_pc   = 8'h00;
        free_run = 0;
        halt_st  = 1'b0;
        for (int c = 0; c < int'(NRAND); c++) begin
            r  = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) halt_st = ~halt_st;
            h  = halt_st;
            rd = ($urandom_range(0, 24) == 0);
            rp = 8'($urandom);
            // Two consecutive cycles free of halt/redirect guarantee a word at the head.
            if (free_run >= 2) check("rand liveness", 64'(bus.ins_valid), 64'(1));
            if (bus.ins_valid && r) begin
                check("rand ins_pc", 64'(bus.ins_pc), 64'(exp_pc));
                check("rand ins", 64'(bus.ins), 64'(mem[exp_pc[7:2]]));
                exp_pc = exp_pc + 8'd4;
            end
            if (rd) exp_pc = rp & 8'hFC;
            free_run = (rd || h) ? 0 : free_run + 1;
            drive(r, h, rd, rp);
            step();
        end

        drive(1'b0, 1'b0, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
